mem_bus_arbiter: RTL and testbench
==================================

Name: mem_bus_arbiter

Overview:
- Shares the single external memory pin interface between two requesters: r0 is the CPU core and r1 is the loader/debug port.
- The pin interface is a 15-bit request bus, a write flag and an 8-bit read bus.
- The block accepts one transaction at a time with a valid/ready handshake, sequences the address, write-data and read-wait phases on the pins, and returns a one-cycle response pulse to the owning requester.
- It sits between the core/loader and the top-level pin mapping.

Parameters:
- ADDR_W, 15, address width; equals the request bus width.
- DATA_W, 8, data width.
- READ_LAT, 2, number of cycles from address phase to read-data sample on the pins; legal range 1..15.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- r0_valid  in  1  CPU request valid
- r0_ready  out  1  CPU request accepted this cycle
- r0_addr  in  ADDR_W  CPU address
- r0_we  in  1  CPU write (1) / read (0)
- r0_wdata  in  DATA_W  CPU write data
- r0_rsp_valid  out  1  CPU response pulse
- r0_rdata  out  DATA_W  CPU read data
- r1_valid, r1_ready, r1_addr, r1_we, r1_wdata, r1_rsp_valid, r1_rdata: same as r0, for the loader
- bus_req  out  ADDR_W  pin request bus (address, or write data in [7:0])
- bus_write  out  1  pin write flag
- bus_rd  in  DATA_W  pin read bus
- busy  out  1  transaction in flight (state != IDLE)
- grant_id  out  1  owner of current or last transaction

Behaviour:
- Reset is asynchronous, active-low. All outputs are 0, state is IDLE, latched payload and rdata registers are 0, and grant_id is 0. Reset mid-transaction aborts it with no response pulse.
- FSM states: IDLE, ADDR, WDATA, WAIT, DONE.
- IDLE:
  - bus_req=0, bus_write=0.
  - rX_ready is combinational: it is 1 only for the selected winner, and only while that winner's rX_valid=1.
  - On valid&ready: latch addr/we/wdata, set grant_id, go to ADDR.
  - rX_ready=0 in every other state.
- Arbitration (default): fixed priority; r0 wins when both are valid.
- ADDR (1 cycle): bus_req=addr, bus_write=we. Next state is WDATA if we=1, else WAIT with counter loaded to READ_LAT-1.
- WDATA (1 cycle): bus_req={zeros, wdata}, bus_write=1. Next state is DONE.
- WAIT:
  - bus_req holds addr, bus_write=0.
  - Counter decrements each cycle.
  - When the counter is 0, sample bus_rd into the owner's rdata register and go to DONE.
- DONE (1 cycle): owner's rX_rsp_valid=1. Next state is IDLE.
- rX_rdata:
  - Holds its value until the next read by the same requester.
  - Writes leave rdata unchanged.
  - The other requester's rdata is never modified.
- Timing, with the accept cycle as cycle 0:
  - Read: ADDR at c1, WAIT at c2..c(1+READ_LAT), rsp_valid at c(2+READ_LAT).
  - Write: ADDR at c1, WDATA at c2, rsp_valid at c3.
  - Next accept is possible in the cycle after DONE.
- Requesters hold valid and payload stable until ready. Dropping valid before ready is legal and starts no transaction.
- Requests arriving while busy are stalled, not dropped.
- Address upper bits are passed through unmodified. There is no address range checking.

Optional Feature:
- Macro: MEM_BUS_ARB_ROUND_ROBIN_EN.
- Defined: 2-way round robin.
  - A last_grant register (reset 0) is updated on every accept.
  - When both requesters are valid, the one not last granted wins.
  - A single valid requester always wins.
- Undefined: fixed priority r0 > r1. The last_grant register does not exist.

Decomposition:
- Package mem_bus_pkg holds:
  - ADDR_W and DATA_W constants.
  - State enum typedef (IDLE, ADDR, WDATA, WAIT, DONE).
  - Requester-id typedef (1 bit).
- One sub-module, mem_bus_rr_arb: combinational 2-way winner select plus the optional last_grant register. It is instantiated once by mem_bus_arbiter.

Test Plan:
- r0 read addr 0x1234, READ_LAT=2, bus_rd=0xA5 during the WAIT cycles -> bus_req=0x1234 at c1..c3, bus_write=0, r0_rsp_valid at c4, r0_rdata=0xA5, r1_rdata stays 0.
- r1 write addr 0x7FFF data 0x3C -> c1 bus_req=0x7FFF with bus_write=1, c2 bus_req=0x003C with bus_write=1, r1_rsp_valid at c3, r1_rdata unchanged.
- r0 and r1 both valid for 4 transactions, macro undefined -> all grants go to r0, and r1_ready stays 0 until r0 drops valid.
- Same stimulus with MEM_BUS_ARB_ROUND_ROBIN_EN defined -> grants alternate r0, r1, r0, r1.
- rst_n asserted during WAIT of an r0 read -> all outputs 0 immediately, no r0_rsp_valid, state IDLE; a new r1 read after release completes normally.
- r1_valid raised during a busy r0 write -> r1_ready=0 until IDLE, then r1 is accepted in the cycle after r0's DONE.

Source files
------------

// File: rtl/mem_bus_pkg.sv
// Shared constants and types for the external memory bus arbiter.
package mem_bus_pkg;

  localparam int ADDR_W = 15;
  localparam int DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    WDATA,
    WAIT,
    DONE
  } state_t;

  typedef logic req_id_t;

endpackage

// File: rtl/mem_bus_rr_arb.sv
// Two-way winner select for the memory bus arbiter.
// MEM_BUS_ARB_ROUND_ROBIN_EN selects round robin; otherwise r0 has fixed priority.
module mem_bus_rr_arb
  import mem_bus_pkg::*;
(
  input  logic    clk,
  input  logic    rst_n,
  input  logic    valid0,
  input  logic    valid1,
  input  logic    accept,
  output req_id_t winner
);

`ifdef MEM_BUS_ARB_ROUND_ROBIN_EN
  req_id_t last_grant;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= '0;
    end else if (accept) begin
      last_grant <= winner;
    end
  end

  always_comb begin
    if (valid0 && valid1) begin
      winner = ~last_grant;
    end else begin
      winner = valid1;
    end
  end
`else
  logic unused_rr;
  assign unused_rr = &{1'b0, clk, rst_n, accept};

  always_comb begin
    winner = valid1 && !valid0;
  end
`endif

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares the external memory pins between the CPU (r0) and loader (r1).
// Arbitration policy is set by MEM_BUS_ARB_ROUND_ROBIN_EN (see mem_bus_rr_arb).
module mem_bus_arbiter #(
  parameter int ADDR_W   = mem_bus_pkg::ADDR_W,
  parameter int DATA_W   = mem_bus_pkg::DATA_W,
  parameter int READ_LAT = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              r0_valid,
  output logic              r0_ready,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic              r0_we,
  input  logic [DATA_W-1:0] r0_wdata,
  output logic              r0_rsp_valid,
  output logic [DATA_W-1:0] r0_rdata,
  input  logic              r1_valid,
  output logic              r1_ready,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic              r1_we,
  input  logic [DATA_W-1:0] r1_wdata,
  output logic              r1_rsp_valid,
  output logic [DATA_W-1:0] r1_rdata,
  output logic [ADDR_W-1:0] bus_req,
  output logic              bus_write,
  input  logic [DATA_W-1:0] bus_rd,
  output logic              busy,
  output logic              grant_id
);
  import mem_bus_pkg::*;

  localparam int CNT_W = 4;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] addr_q;
  logic              we_q;
  logic [DATA_W-1:0] wdata_q;
  logic [CNT_W-1:0]  cnt;
  req_id_t           owner;
  req_id_t           winner;
  logic              in_idle;
  logic              accept;

  mem_bus_rr_arb u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .valid0 (r0_valid),
    .valid1 (r1_valid),
    .accept (accept),
    .winner (winner)
  );

  // rst_n gating keeps ready low while reset is held even if a requester is valid
  assign in_idle  = (state == IDLE) && rst_n;
  assign r0_ready = in_idle && r0_valid && (winner == 1'b0);
  assign r1_ready = in_idle && r1_valid && (winner == 1'b1);
  assign accept   = r0_ready || r1_ready;
  assign busy     = (state != IDLE);
  assign grant_id = owner;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = ADDR;
      ADDR:    state_nxt = we_q ? WDATA : WAIT;
      WDATA:   state_nxt = DONE;
      WAIT:    if (cnt == '0) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q   <= '0;
      we_q     <= 1'b0;
      wdata_q  <= '0;
      cnt      <= '0;
      owner    <= '0;
      r0_rdata <= '0;
      r1_rdata <= '0;
    end else begin
      if (accept) begin
        addr_q  <= r1_ready ? r1_addr  : r0_addr;
        we_q    <= r1_ready ? r1_we    : r0_we;
        wdata_q <= r1_ready ? r1_wdata : r0_wdata;
        owner   <= winner;
      end
      if (state == ADDR) begin
        cnt <= CNT_W'(READ_LAT - 1);
      end else if (state == WAIT && cnt != '0) begin
        cnt <= cnt - CNT_W'(1);
      end
      if (state == WAIT && cnt == '0) begin
        if (owner) begin
          r1_rdata <= bus_rd;
        end else begin
          r0_rdata <= bus_rd;
        end
      end
    end
  end

  always_comb begin
    bus_req      = '0;
    bus_write    = 1'b0;
    r0_rsp_valid = 1'b0;
    r1_rsp_valid = 1'b0;
    case (state)
      ADDR: begin
        bus_req   = addr_q;
        bus_write = we_q;
      end
      WDATA: begin
        bus_req   = ADDR_W'(wdata_q);
        bus_write = 1'b1;
      end
      WAIT: begin
        bus_req = addr_q;
      end
      DONE: begin
        r0_rsp_valid = (owner == 1'b0);
        r1_rsp_valid = (owner == 1'b1);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter; follows MEM_BUS_ARB_ROUND_ROBIN_EN for grant order.
module tb_mem_bus_arbiter;

  localparam int AW = 15;
  localparam int DW = 8;
  localparam int RL = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          r0_valid = 1'b0, r0_we = 1'b0;
  logic [AW-1:0] r0_addr = '0;
  logic [DW-1:0] r0_wdata = '0;
  logic          r1_valid = 1'b0, r1_we = 1'b0;
  logic [AW-1:0] r1_addr = '0;
  logic [DW-1:0] r1_wdata = '0;
  logic          r0_ready, r0_rsp_valid, r1_ready, r1_rsp_valid;
  logic [DW-1:0] r0_rdata, r1_rdata;
  logic [AW-1:0] bus_req;
  logic          bus_write, busy, grant_id;
  logic [DW-1:0] bus_rd;
  logic [DW-1:0] rd_val = '0;

  always #5 clk = ~clk;
  assign bus_rd = rd_val;

  mem_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .READ_LAT(RL)) dut (
    .clk(clk), .rst_n(rst_n),
    .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_addr(r0_addr), .r0_we(r0_we),
    .r0_wdata(r0_wdata), .r0_rsp_valid(r0_rsp_valid), .r0_rdata(r0_rdata),
    .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_addr(r1_addr), .r1_we(r1_we),
    .r1_wdata(r1_wdata), .r1_rsp_valid(r1_rsp_valid), .r1_rdata(r1_rdata),
    .bus_req(bus_req), .bus_write(bus_write), .bus_rd(bus_rd),
    .busy(busy), .grant_id(grant_id)
  );

  typedef struct {
    logic          id;
    logic [DW-1:0] rdata;
  } exp_t;

  exp_t          sb[$];
  int unsigned   n_cmp = 0;
  int unsigned   n_err = 0;
  logic [DW-1:0] model_rd [2];
  logic          model_last = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, want, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic id, input logic v, input logic we,
                       input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (id) begin
      r1_valid = v; r1_we = we; r1_addr = a; r1_wdata = d;
    end else begin
      r0_valid = v; r0_we = we; r0_addr = a; r0_wdata = d;
    end
  endtask

  function automatic logic rsp_of(input logic id);
    return id ? r1_rsp_valid : r0_rsp_valid;
  endfunction

  function automatic void push_exp(input logic id, input logic we, input logic [DW-1:0] rdv);
    exp_t e;
    if (!we) model_rd[id] = rdv;
    e.id    = id;
    e.rdata = model_rd[id];
    sb.push_back(e);
    model_last = id;
  endfunction

  function automatic logic exp_winner(input logic v0, input logic v1);
`ifdef MEM_BUS_ARB_ROUND_ROBIN_EN
    if (v0 && v1) return ~model_last;
`else
    if (v0 && v1) return 1'b0;
`endif
    return v1 && !v0;
  endfunction

  // Response monitor: pops the scoreboard on every response pulse
  always @(negedge clk) begin
    exp_t e;
    if (r0_rsp_valid || r1_rsp_valid) begin
      if (sb.size() == 0) begin
        check("rsp_unexpected", 1, 0);
      end else begin
        e = sb.pop_front();
        check("rsp_both", r0_rsp_valid & r1_rsp_valid, 0);
        check("rsp_owner", r1_rsp_valid, e.id);
        check("rsp_rdata", e.id ? r1_rdata : r0_rdata, e.rdata);
        check("other_rdata", e.id ? r0_rdata : r1_rdata, model_rd[~e.id]);
      end
    end
  end

  task automatic wait_drain(input int n);
    for (int i = 0; i < n && sb.size() > 0; i++) tick();
    check("drain", sb.size(), 0);
    tick();
  endtask

  task automatic do_txn(input logic id, input logic we, input logic [AW-1:0] addr,
                        input logic [DW-1:0] wd, input logic [DW-1:0] rdv);
    bit got;
    got = 1'b0;
    @(negedge clk);
    rd_val = rdv;
    drive(id, 1'b1, we, addr, wd);
    for (int i = 0; i < 20 && !got; i++) begin
      #1;
      if ((id ? r1_ready : r0_ready) === 1'b1) got = 1'b1;
      else @(negedge clk);
    end
    check("accept", got, 1);
    if (!got) begin
      drive(id, 1'b0, we, addr, wd);
      return;
    end
    push_exp(id, we, rdv);
    tick();
    drive(id, 1'b0, we, addr, wd);
    check("c1_req", bus_req, addr);
    check("c1_write", bus_write, we);
    if (we) begin
      tick();
      check("wd_req", bus_req, AW'(wd));
      check("wd_write", bus_write, 1);
    end else begin
      for (int k = 0; k < RL; k++) begin
        tick();
        check("wait_req", bus_req, addr);
        check("wait_write", bus_write, 0);
        check("wait_rsp", rsp_of(id), 0);
      end
    end
    tick();
    check("rsp", rsp_of(id), 1);
    check("rsp_other", rsp_of(~id), 0);
    tick();
    check("idle_busy", busy, 0);
    check("grant_id", grant_id, id);
  endtask

  task automatic run_contention(input int n);
    int   c0, c1;
    logic ew;
    c0 = n;
    c1 = n;
    for (int it = 0; it < 400 && (c0 > 0 || c1 > 0); it++) begin
      @(negedge clk);
      drive(1'b0, c0 > 0, 1'b0, AW'(32'h0100 + c0), '0);
      drive(1'b1, c1 > 0, 1'b0, AW'(32'h4200 + c1), '0);
      #1;
      if (r0_ready === 1'b1 || r1_ready === 1'b1) begin
        ew = exp_winner(c0 > 0, c1 > 0);
        check("grant", r1_ready, ew);
        check("loser_ready", ew ? r0_ready : r1_ready, 0);
        rd_val = DW'(32'hC0 + it);
        push_exp(ew, 1'b0, rd_val);
        if (ew) c1--;
        else c0--;
      end
    end
    check("cont_done", c0 + c1, 0);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    drive(1'b1, 1'b0, 1'b0, '0, '0);
    wait_drain(40);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_rd[0] = '0;
    model_rd[1] = '0;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_req", bus_req, 0);
    check("rst_write", bus_write, 0);
    check("rst_grant", grant_id, 0);
    check("rst_rdata", {r0_rdata, r1_rdata}, 0);
    check("rst_rsp", {r0_rsp_valid, r1_rsp_valid}, 0);
    rst_n = 1'b1;

    do_txn(1'b0, 1'b0, 15'h1234, 8'h00, 8'hA5);
    do_txn(1'b1, 1'b1, 15'h7FFF, 8'h3C, 8'h11);

    // r1 raised while r0 write is in flight
    @(negedge clk);
    rd_val = 8'h5E;
    drive(1'b0, 1'b1, 1'b1, 15'h0055, 8'h99);
    #1;
    check("st_r0_ready", r0_ready, 1);
    push_exp(1'b0, 1'b1, 8'h00);
    tick();
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    drive(1'b1, 1'b1, 1'b0, 15'h2222, '0);
    #1;
    check("st_r1_c1", r1_ready, 0);
    tick(); #1;
    check("st_r1_c2", r1_ready, 0);
    tick(); #1;
    check("st_r1_c3", r1_ready, 0);
    check("st_r0_rsp", r0_rsp_valid, 1);
    tick(); #1;
    check("st_r1_c4", r1_ready, 1);
    push_exp(1'b1, 1'b0, 8'h5E);
    tick();
    drive(1'b1, 1'b0, 1'b0, '0, '0);
    wait_drain(30);

    // reset during WAIT of an r0 read
    @(negedge clk);
    rd_val = 8'h77;
    drive(1'b0, 1'b1, 1'b0, 15'h0ABC, '0);
    #1;
    check("rst_accept", r0_ready, 1);
    push_exp(1'b0, 1'b0, 8'h77);
    tick();
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    tick();
    #1 rst_n = 1'b0;
    #1;
    check("arst_req", bus_req, 0);
    check("arst_write", bus_write, 0);
    check("arst_busy", busy, 0);
    check("arst_grant", grant_id, 0);
    check("arst_rdata", {r0_rdata, r1_rdata}, 0);
    check("arst_rsp", {r0_rsp_valid, r1_rsp_valid}, 0);
    sb.delete();
    model_rd[0] = '0;
    model_rd[1] = '0;
    model_last  = 1'b0;
    repeat (3) begin
      tick();
      check("arst_no_rsp", r0_rsp_valid, 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    do_txn(1'b1, 1'b0, 15'h5555, 8'h00, 8'hC3);

    run_contention(4);

    for (int i = 0; i < 6; i++) begin
      do_txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), AW'($urandom),
             DW'($urandom), DW'($urandom));
    end

    wait_drain(20);
    check("sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
